// File: rtl/csi2_lane_tx.sv
// ============================================================================
// Module      : csi2_lane_tx
// Description : MIPI CSI-2 style multi-lane serial transmitter. Each packet runs
//               LP-11 -> LP-01 -> LP-00 -> HS-0 -> sync byte -> data -> trail.
//               Packet counter is built only when CSI2_LANE_TX_PKT_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csi2_lane_tx #(
  parameter int LANES     = 2,
  parameter int LPX_CYC   = 2,
  parameter int PREP_CYC  = 3,
  parameter int ZERO_CYC  = 4,
  parameter int TRAIL_CYC = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [8*LANES-1:0] data_i,
  input  logic               valid_i,
  input  logic               last_i,
  output logic               ready_o,
  output logic [LANES-1:0]   do_p_o,
  output logic [LANES-1:0]   do_n_o,
  output logic               busy_o,
  output logic               underrun_o,
  output logic [15:0]        pkt_cnt_o
);

  localparam logic [2:0] ST_STOP   = 3'd0;
  localparam logic [2:0] ST_HSRQ   = 3'd1;
  localparam logic [2:0] ST_BRIDGE = 3'd2;
  localparam logic [2:0] ST_ZERO   = 3'd3;
  localparam logic [2:0] ST_SYNC   = 3'd4;
  localparam logic [2:0] ST_DATA   = 3'd5;
  localparam logic [2:0] ST_TRAIL  = 3'd6;

  localparam logic [7:0] SYNC_BYTE  = 8'hB8;
  localparam logic [7:0] LPX_LAST   = 8'(LPX_CYC - 1);
  localparam logic [7:0] PREP_LAST  = 8'(PREP_CYC - 1);
  localparam logic [7:0] ZERO_LAST  = 8'(ZERO_CYC - 1);
  localparam logic [7:0] TRAIL_LAST = 8'(TRAIL_CYC - 1);

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [7:0]         timer;
  logic [2:0]         bit_cnt;
  logic [8*LANES-1:0] shreg;
  logic               last_seen;
  logic [LANES-1:0]   trail_bit;
  logic [LANES-1:0]   hs_bit;
  logic               bit7;
  logic               timed;
  logic               accept;

  assign bit7   = (bit_cnt == 3'd7);
  assign timed  = (state == ST_HSRQ) || (state == ST_BRIDGE) ||
                  (state == ST_ZERO) || (state == ST_TRAIL);
  assign accept = ready_o & valid_i;

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [7:0] lane_byte;
      assign lane_byte = shreg[8*k +: 8];
      assign hs_bit[k] = (state == ST_SYNC) ? SYNC_BYTE[bit_cnt] : lane_byte[bit_cnt];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_STOP;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_STOP:   if (valid_i)              state_nxt = ST_HSRQ;
      ST_HSRQ:   if (timer == LPX_LAST)    state_nxt = ST_BRIDGE;
      ST_BRIDGE: if (timer == PREP_LAST)   state_nxt = ST_ZERO;
      ST_ZERO:   if (timer == ZERO_LAST)   state_nxt = ST_SYNC;
      ST_SYNC:   if (bit7)                 state_nxt = valid_i ? ST_DATA : ST_TRAIL;
      ST_DATA:   if (bit7 && (last_seen || !valid_i)) state_nxt = ST_TRAIL;
      ST_TRAIL:  if (timer == TRAIL_LAST)  state_nxt = ST_STOP;
      default:                             state_nxt = ST_STOP;
    endcase
  end

  always_comb begin
    do_p_o     = '1;
    do_n_o     = '1;
    ready_o    = bit7 && ((state == ST_SYNC) || ((state == ST_DATA) && !last_seen));
    underrun_o = ready_o && !valid_i;
    busy_o     = (state != ST_STOP);
    case (state)
      ST_HSRQ, ST_ZERO: begin
        do_p_o = '0;
        do_n_o = '1;
      end
      ST_BRIDGE: begin
        do_p_o = '0;
        do_n_o = '0;
      end
      ST_SYNC, ST_DATA: begin
        do_p_o = hs_bit;
        do_n_o = ~hs_bit;
      end
      ST_TRAIL: begin
        do_p_o = ~trail_bit;
        do_n_o = trail_bit;
      end
      default: ;
    endcase
  end

  // The bit counter wraps 7->0 on its own, giving gapless word-to-word transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer     <= 8'd0;
      bit_cnt   <= 3'd0;
      shreg     <= '0;
      last_seen <= 1'b0;
      trail_bit <= '0;
    end else begin
      if ((state_nxt != state) || !timed) begin
        timer <= 8'd0;
      end else begin
        timer <= timer + 8'd1;
      end
      if ((state == ST_SYNC) || (state == ST_DATA)) begin
        bit_cnt <= bit_cnt + 3'd1;
      end else begin
        bit_cnt <= 3'd0;
      end
      if (accept) begin
        shreg     <= data_i;
        last_seen <= last_i;
      end
      if ((state_nxt == ST_TRAIL) && (state != ST_TRAIL)) begin
        trail_bit <= hs_bit;
      end
    end
  end

`ifdef CSI2_LANE_TX_PKT_CNT_EN
  logic [15:0] pkt_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pkt_cnt <= 16'd0;
    end else if ((state == ST_TRAIL) && (state_nxt == ST_STOP)) begin
      pkt_cnt <= pkt_cnt + 16'd1;
    end
  end

  assign pkt_cnt_o = pkt_cnt;
`else
  assign pkt_cnt_o = 16'd0;
`endif

endmodule

`default_nettype wire

// File: doc/csi2_lane_tx.md
CSI2_LANE_TX -- requirements
Module: csi2_lane_tx

Interface
REQ-001 The block SHALL have parameter LANES, default 2: number of data lanes, legal 1..4.
REQ-002 The block SHALL have parameter LPX_CYC, default 2: cycles in LP-01 (HS request).
REQ-003 The block SHALL have parameter PREP_CYC, default 3: cycles in LP-00 (HS prepare).
REQ-004 The block SHALL have parameter ZERO_CYC, default 4: cycles of HS-0 before the sync byte.
REQ-005 The block SHALL have parameter TRAIL_CYC, default 3: cycles of HS trail.
REQ-006 The block SHALL have port clk_i, input, 1 bit: bit clock; one serial bit per lane per rising edge.
REQ-007 The block SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-008 The block SHALL have port data_i, input, 8*LANES bits: byte k (bits 8k+7:8k) goes to lane k.
REQ-009 The block SHALL have port valid_i, input, 1 bit: data_i holds a valid word.
REQ-010 The block SHALL have port last_i, input, 1 bit: the current word is the final word of the packet.
REQ-011 The block SHALL have port ready_o, output, 1 bit: a word is accepted on a cycle where valid_i and ready_o are both high.
REQ-012 The block SHALL have port do_p_o, output, LANES bits: positive line of each lane.
REQ-013 The block SHALL have port do_n_o, output, LANES bits: negative line of each lane.
REQ-014 The block SHALL have port busy_o, output, 1 bit: high in every state except STOP.
REQ-015 The block SHALL have port underrun_o, output, 1 bit: one-cycle pulse when a word is missing mid-packet.
REQ-016 The block SHALL have port pkt_cnt_o, output, 16 bits: count of completed packets.

Function
REQ-017 The block SHALL use states STOP, HSRQ, BRIDGE, ZERO, SYNC, DATA and TRAIL.
REQ-018 Each lane SHALL drive the following line pairs (p,n): STOP (1,1); HSRQ (0,1); BRIDGE (0,0); ZERO (0,1); SYNC, DATA and HS bits (b,~b); TRAIL (~lastbit,lastbit) held.
REQ-019 When in STOP with valid_i high, the block SHALL enter HSRQ on the next cycle; the word SHALL NOT be consumed in STOP.
REQ-020 The HSRQ, BRIDGE and ZERO states SHALL each last exactly LPX_CYC, PREP_CYC and ZERO_CYC cycles respectively, then advance.
REQ-021 In SYNC, all lanes SHALL serialize 0xB8 LSB first over 8 cycles (bits 0,0,0,1,1,1,0,1).
REQ-022 In DATA, each lane SHALL serialize its byte LSB first, one bit per cycle, with a 3-bit counter (0..7).
REQ-023 ready_o SHALL be high only in the bit-7 cycle of SYNC, and in the bit-7 cycle of DATA when last_i has not yet been accepted; ready_o SHALL be combinational from state and counter only.
REQ-024 If a word is accepted at bit 7, the next cycle SHALL start that word at bit 0 with no gap.
REQ-025 After the last word's bit 7, the block SHALL enter TRAIL; each lane SHALL hold the inverse of its own final data bit for TRAIL_CYC cycles, then enter STOP.
REQ-026 If ready_o is high and valid_i is low, underrun_o SHALL pulse, the block SHALL enter TRAIL based on the last transmitted bit, and the packet SHALL still count as completed.
REQ-027 The TRAIL-to-STOP transition SHALL increment pkt_cnt_o, wrapping at 0xFFFF to 0.
REQ-028 A valid_i that is already high on the cycle after TRAIL ends SHALL start a new HSRQ; the minimum time spent in STOP is 1 cycle.
REQ-029 Timer counters SHALL be sized for parameter values up to 255; parameter values of 0 SHALL be illegal.

Reset
REQ-030 While rst_i is high at a clock edge, the block SHALL be in STOP with do_p_o and do_n_o all 1, ready_o=0, busy_o=0, underrun_o=0, pkt_cnt_o=0, and all timers at 0.
REQ-031 A reset asserted mid-packet SHALL abort the packet with no trail and no count increment; LP-11 SHALL be driven on the next cycle.

Configuration
REQ-032 With CSI2_LANE_TX_PKT_CNT_EN defined, pkt_cnt_o SHALL behave per REQ-027.
REQ-033 Without CSI2_LANE_TX_PKT_CNT_EN, pkt_cnt_o SHALL be constant 0 and no counter flops SHALL be generated.

Verification
REQ-034 Scenario, defaults, one word {0xA5,0x3C} with last: lane0 shows 11, 01x2, 00x3, 01x4, then B8, A5 LSB first, then trail (0,1)x3, then 11; lane1 shows 3C and trail (1,0); pkt_cnt_o=1.
REQ-035 Scenario, three words with valid_i held high: data is contiguous with no idle bits, ready_o pulses exactly 3 times, spaced 8 cycles apart.
REQ-036 Scenario, valid_i dropped before the second word: underrun_o=1 for 1 cycle, trail follows the first word, STOP is reached, and pkt_cnt_o increments.
REQ-037 Scenario, rst_i asserted at DATA bit 4: the next cycle shows all lanes at 11, busy_o=0, and pkt_cnt_o unchanged.
REQ-038 Scenario, LANES=1 and LANES=4, one word 0xFF per lane: each lane trails (0,1) and the sync byte is identical on all lanes.
REQ-039 Scenario, macro undefined, 5 packets: pkt_cnt_o stays 0 throughout.
